// File: rtl/video_dram_sched.sv
// Shares one DRAM port between video fetch, CPU and refresh, one DRAM cycle at a time.
// Video owns fixed slots of a 16-cycle fetch period; CPU/refresh share the rest by priority.
module video_dram_sched #(
    parameter int unsigned DATA_LAT    = 4,
    parameter int unsigned REFR_PERIOD = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dram_cyc_start,
    input  logic       fetch_sync,
    input  logic       video_go,
    input  logic [1:0] bw_mode,
    input  logic       cpu_req,
    input  logic       cpu_rnw,
    output logic       grant_video,
    output logic       grant_cpu,
    output logic       grant_refr,
    output logic       cpu_ack,
    output logic       video_strobe,
    output logic       cpu_strobe,
    output logic [1:0] refr_pend
);
    localparam int unsigned SLOT_W = 4;
    localparam int unsigned PEND_W = 2;
    localparam int unsigned DIV_W  = $clog2(REFR_PERIOD);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFR_PERIOD - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [SLOT_W-1:0]   slot_q, slot_d, slot_new;
    logic                sync_flag_q, sync_flag_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                gv_q, gv_d, gc_q, gc_d, gr_q, gr_d;
    logic                ack_q, ack_d;
    logic [DATA_LAT-1:0] vsr_q, vsr_d, csr_q, csr_d;

    logic vslot, pick_urgent, pick_cpu, pick_refr;
    logic refr_inc, refr_dec, vload, cload;

    // Slot of the cycle being started; a coincident fetch_sync forces slot 0.
    always_comb begin
        slot_new = (sync_flag_q || fetch_sync) ? '0 : slot_q + SLOT_W'(1);
        vslot    = 1'b0;
        case (bw_mode)
            2'b01:   vslot = video_go && (slot_new[2:0] == 3'b111);
            2'b10:   vslot = video_go && (slot_new[1:0] == 2'b11);
            2'b11:   vslot = video_go && slot_new[0];
            default: vslot = 1'b0;
        endcase
    end

    // Priority: video slot, urgent refresh, CPU, pending refresh.
    always_comb begin
        pick_urgent = !vslot && (pend_q == PEND_MAX);
        pick_cpu    = !vslot && !pick_urgent && cpu_req;
        pick_refr   = pick_urgent || (!vslot && !cpu_req && (pend_q != '0));
    end

    always_comb begin
        sync_flag_d = sync_flag_q | fetch_sync;
        slot_d      = slot_q;
        div_d       = div_q;
        gv_d        = gv_q;
        gc_d        = gc_q;
        gr_d        = gr_q;
        ack_d       = 1'b0;
        refr_inc    = 1'b0;
        refr_dec    = 1'b0;
        vload       = 1'b0;
        cload       = 1'b0;
        if (dram_cyc_start) begin
            sync_flag_d = 1'b0;
            slot_d      = slot_new;
            refr_inc    = (div_q == DIV_LAST);
            div_d       = refr_inc ? '0 : div_q + DIV_W'(1);
            refr_dec    = pick_refr;
            gv_d        = vslot;
            gc_d        = pick_cpu;
            gr_d        = pick_refr;
            ack_d       = pick_cpu;
            vload       = vslot;
            cload       = pick_cpu && cpu_rnw;
        end

        pend_d = pend_q;
        if (refr_inc && !refr_dec && (pend_q != PEND_MAX)) begin
            pend_d = pend_q + PEND_W'(1);
        end else if (refr_dec && !refr_inc) begin
            pend_d = pend_q - PEND_W'(1);
        end

        // Each grant enters its own latency line, unaffected by later grants.
        vsr_d = (vsr_q << 1) | DATA_LAT'(vload);
        csr_d = (csr_q << 1) | DATA_LAT'(cload);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            sync_flag_q <= 1'b0;
            div_q       <= '0;
            pend_q      <= '0;
            gv_q        <= 1'b0;
            gc_q        <= 1'b0;
            gr_q        <= 1'b0;
            ack_q       <= 1'b0;
            vsr_q       <= '0;
            csr_q       <= '0;
        end else begin
            slot_q      <= slot_d;
            sync_flag_q <= sync_flag_d;
            div_q       <= div_d;
            pend_q      <= pend_d;
            gv_q        <= gv_d;
            gc_q        <= gc_d;
            gr_q        <= gr_d;
            ack_q       <= ack_d;
            vsr_q       <= vsr_d;
            csr_q       <= csr_d;
        end
    end

    assign grant_video  = gv_q;
    assign grant_cpu    = gc_q;
    assign grant_refr   = gr_q;
    assign cpu_ack      = ack_q;
    assign video_strobe = vsr_q[DATA_LAT-1];
    assign cpu_strobe   = csr_q[DATA_LAT-1];
    assign refr_pend    = pend_q;

endmodule

// File: tb/tb_video_dram_sched.sv
// Directed bench for video_dram_sched: two instances (latency 4 and 12) share stimulus;
// grants are checked per DRAM cycle, strobes against an expected-time map every clk.
module tb_video_dram_sched;
    localparam int unsigned LAT_A = 4;
    localparam int unsigned LAT_B = 12;
    localparam int NCYC = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dram_cyc_start = 1'b0;
    logic       fetch_sync = 1'b0;
    logic       video_go = 1'b0;
    logic [1:0] bw_mode = 2'b00;
    logic       cpu_req = 1'b0;
    logic       cpu_rnw = 1'b0;

    logic gv_a, gc_a, gr_a, ack_a, vs_a, cs_a;
    logic gv_b, gc_b, gr_b, ack_b, vs_b, cs_b;
    logic [1:0] pend_a, pend_b;

    int  checks = 0;
    int  errors = 0;
    int  pe = 0;
    bit  mon_en = 1'b0;
    bit  exp_vs_a [NCYC];
    bit  exp_cs_a [NCYC];
    bit  exp_vs_b [NCYC];
    bit  exp_cs_b [NCYC];

    typedef struct {
        bit       fs;
        bit       vgo;
        bit [1:0] bw;
        bit       creq;
        bit       rnw;
        int       gap;
        bit       gv;
        bit       gc;
        bit       gr;
    } vec_t;
    vec_t tbl[$];

    video_dram_sched #(.DATA_LAT(LAT_A), .REFR_PERIOD(96)) dut_a (
        .clk(clk), .rst_n(rst_n), .dram_cyc_start(dram_cyc_start), .fetch_sync(fetch_sync),
        .video_go(video_go), .bw_mode(bw_mode), .cpu_req(cpu_req), .cpu_rnw(cpu_rnw),
        .grant_video(gv_a), .grant_cpu(gc_a), .grant_refr(gr_a), .cpu_ack(ack_a),
        .video_strobe(vs_a), .cpu_strobe(cs_a), .refr_pend(pend_a)
    );

    video_dram_sched #(.DATA_LAT(LAT_B), .REFR_PERIOD(96)) dut_b (
        .clk(clk), .rst_n(rst_n), .dram_cyc_start(dram_cyc_start), .fetch_sync(fetch_sync),
        .video_go(video_go), .bw_mode(bw_mode), .cpu_req(cpu_req), .cpu_rnw(cpu_rnw),
        .grant_video(gv_b), .grant_cpu(gc_b), .grant_refr(gr_b), .cpu_ack(ack_b),
        .video_strobe(vs_b), .cpu_strobe(cs_b), .refr_pend(pend_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pe <= pe + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (clk %0d)", name, act, exp, pe);
        end
    endtask

    // Strobes must appear exactly where the bench scheduled them, and nowhere else.
    always @(negedge clk) begin
        if (mon_en && rst_n && pe < NCYC) begin
            chk("video_strobe_lat4", int'(vs_a), int'(exp_vs_a[pe]));
            chk("cpu_strobe_lat4", int'(cs_a), int'(exp_cs_a[pe]));
            chk("video_strobe_lat12", int'(vs_b), int'(exp_vs_b[pe]));
            chk("cpu_strobe_lat12", int'(cs_b), int'(exp_cs_b[pe]));
        end
    end

    task automatic sched(input bit is_cpu, input int k);
        int ia;
        int ib;
        ia = k + int'(LAT_A) - 1;
        ib = k + int'(LAT_B) - 1;
        if (ia < NCYC && ib < NCYC) begin
            if (is_cpu) begin
                exp_cs_a[ia] = 1'b1;
                exp_cs_b[ib] = 1'b1;
            end else begin
                exp_vs_a[ia] = 1'b1;
                exp_vs_b[ib] = 1'b1;
            end
        end
    endtask

    // One DRAM cycle: pulse start, check grants/ack one clk later, then wait out the gap.
    task automatic pulse(input bit fs, input int gap, input bit gv, input bit gc, input bit gr,
                         input string tag);
        @(negedge clk);
        dram_cyc_start = 1'b1;
        fetch_sync     = fs;
        @(negedge clk);
        dram_cyc_start = 1'b0;
        fetch_sync     = 1'b0;
        chk({tag, "_grant_video"}, int'(gv_a), int'(gv));
        chk({tag, "_grant_cpu"}, int'(gc_a), int'(gc));
        chk({tag, "_grant_refr"}, int'(gr_a), int'(gr));
        chk({tag, "_cpu_ack"}, int'(ack_a), int'(gc));
        chk({tag, "_b_grants"}, int'({gv_b, gc_b, gr_b, ack_b}), int'({gv, gc, gr, gc}));
        if (gv) sched(1'b0, pe);
        if (gc && cpu_rnw) sched(1'b1, pe);
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_outs_lat4"}, int'({gv_a, gc_a, gr_a, ack_a, vs_a, cs_a, pend_a}), 0);
        chk({tag, "_outs_lat12"}, int'({gv_b, gc_b, gr_b, ack_b, vs_b, cs_b, pend_b}), 0);
    endtask

    task automatic assert_reset(input string tag);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_zero(tag);
        for (int i = 0; i < NCYC; i++) begin
            exp_vs_a[i] = 1'b0;
            exp_cs_a[i] = 1'b0;
            exp_vs_b[i] = 1'b0;
            exp_cs_b[i] = 1'b0;
        end
        video_go = 1'b0;
        bw_mode  = 2'b00;
        cpu_req  = 1'b0;
        cpu_rnw  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        repeat (14) @(negedge clk);
        assert_reset(tag);
    endtask

    task automatic sync_pulse();
        @(negedge clk);
        fetch_sync = 1'b1;
        @(negedge clk);
        fetch_sync = 1'b0;
    endtask

    function automatic void add(input bit fs, input bit vgo, input bit [1:0] bw, input bit creq,
                                input bit rnw, input int gap, input bit gv, input bit gc,
                                input bit gr);
        vec_t v;
        v.fs = fs; v.vgo = vgo; v.bw = bw; v.creq = creq; v.rnw = rnw;
        v.gap = gap; v.gv = gv; v.gc = gc; v.gr = gr;
        tbl.push_back(v);
    endfunction

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            video_go = tbl[i].vgo;
            bw_mode  = tbl[i].bw;
            cpu_req  = tbl[i].creq;
            cpu_rnw  = tbl[i].rnw;
            pulse(tbl[i].fs, tbl[i].gap, tbl[i].gv, tbl[i].gc, tbl[i].gr,
                  $sformatf("%s_v%0d", tag, i));
        end
        tbl.delete();
    endtask

    initial begin
        do_reset("reset_initial");

        // Async reset mid-stream drops the live grant and the in-flight strobe.
        video_go = 1'b1;
        bw_mode  = 2'b11;
        pulse(1'b1, 2, 1'b0, 1'b0, 1'b0, "t1_slot0");
        pulse(1'b0, 2, 1'b1, 1'b0, 1'b0, "t1_slot1");
        assert_reset("t1_async_reset");
        for (int n = 1; n <= 96; n++) begin
            pulse(1'b0, 2, 1'b0, 1'b0, 1'b0, $sformatf("t1_idle%0d", n));
            chk($sformatf("t1_refr_pend_after%0d", n), int'(pend_a), (n == 96) ? 1 : 0);
        end
        pulse(1'b0, 2, 1'b0, 1'b0, 1'b1, "t1_refresh");
        chk("t1_refr_pend_drained", int'(pend_a), 0);

        // Quarter bandwidth: video in slots 3, 7, 11, 15.
        do_reset("t2_reset");
        video_go = 1'b1;
        bw_mode  = 2'b10;
        sync_pulse();
        for (int s = 0; s <= 16; s++) add(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8, (s % 4) == 3, 1'b0, 1'b0);
        run_tbl("t2");

        // Eighth bandwidth with CPU reads filling every other slot.
        do_reset("t3_reset");
        video_go = 1'b1;
        bw_mode  = 2'b01;
        sync_pulse();
        for (int s = 0; s <= 16; s++) begin
            add(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 4, (s % 8) == 7, (s % 8) != 7, 1'b0);
        end
        run_tbl("t3");

        // Refresh urgency versus CPU writes.
        do_reset("t4_reset");
        cpu_req = 1'b1;
        cpu_rnw = 1'b0;
        for (int n = 1; n <= 288; n++) begin
            pulse(1'b0, 2, 1'b0, 1'b1, 1'b0, $sformatf("t4_cpu%0d", n));
            if (n == 96)  chk("t4_refr_pend_1", int'(pend_a), 1);
            if (n == 192) chk("t4_refr_pend_2", int'(pend_a), 2);
            if (n == 288) chk("t4_refr_pend_3", int'(pend_a), 3);
        end
        pulse(1'b0, 2, 1'b0, 1'b0, 1'b1, "t4_urgent");
        chk("t4_refr_pend_after_urgent", int'(pend_a), 2);
        pulse(1'b0, 2, 1'b0, 1'b1, 1'b0, "t4_cpu_at_pend2");
        chk("t4_refr_pend_hold2", int'(pend_a), 2);
        cpu_req = 1'b0;
        pulse(1'b0, 2, 1'b0, 1'b0, 1'b1, "t4_refr_a");
        chk("t4_refr_pend_1b", int'(pend_a), 1);
        pulse(1'b0, 2, 1'b0, 1'b0, 1'b1, "t4_refr_b");
        chk("t4_refr_pend_0", int'(pend_a), 0);
        pulse(1'b0, 2, 1'b0, 1'b0, 1'b0, "t4_idle");

        // Coincident fetch_sync at slot 9, then bw_mode / video_go gating.
        do_reset("t5_reset");
        for (int s = 0; s <= 9; s++) add(s == 0, 1'b1, 2'b11, 1'b0, 1'b0, 2, (s % 2) == 1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        run_tbl("t5");

        // video_go dropped after a grant: the 12-clk strobe still lands, no more grants.
        do_reset("t6_reset");
        video_go = 1'b1;
        bw_mode  = 2'b11;
        sync_pulse();
        pulse(1'b0, 8, 1'b0, 1'b0, 1'b0, "t6_slot0");
        pulse(1'b0, 2, 1'b1, 1'b0, 1'b0, "t6_slot1");
        video_go = 1'b0;
        repeat (6) @(negedge clk);
        for (int s = 2; s <= 5; s++) pulse(1'b0, 8, 1'b0, 1'b0, 1'b0, $sformatf("t6_slot%0d", s));

        repeat (16) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
